// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Provides the scheduler state encoding, the frame timing constants, and
// the default watchdog limit that is derived from those constants.
package uart_pkg;

    localparam int CLK_PER_BIT = 2500;
    localparam int FRAME_BITS  = 10;
    // One full frame plus a 5000-cycle margin before the watchdog declares
    // the transmitter stuck.
    localparam int TIMEOUT_CYC = CLK_PER_BIT * FRAME_BITS + 5000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the requesters, the transmit scheduler and the
// UART byte transmitter.
//   req_valid/req_data/req_ack : per-requester byte offer and capture pulse
//   tx_ready/tx_done           : transmitter status
//   tx_start/tx_data           : start pulse and held byte to transmitter
//   grant_id/busy/timeout_err  : scheduler status
// master = scheduler side, slave = requester/transmitter side.
interface uart_tx_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         req_ack;
    logic                     tx_ready;
    logic                     tx_done;
    logic                     tx_start;
    logic [DATA_W-1:0]        tx_data;
    logic [$clog2(N_REQ)-1:0] grant_id;
    logic                     busy;
    logic                     timeout_err;

    modport master (
        input  req_valid, req_data, tx_ready, tx_done,
        output req_ack, tx_start, tx_data, grant_id, busy, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_ready, tx_done,
        input  req_ack, tx_start, tx_data, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req          : request vector
//   last_grant   : index served most recently (lowest priority now)
//   grant_onehot : one-hot winner, zero when no request
//   grant_idx    : binary index of the winner, zero when no request
// Priority starts at last_grant+1 and wraps modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         grant_onehot,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);
    localparam int IDX_W = $clog2(N_REQ);

    // Scan from the lowest-priority slot (last_grant itself) toward the
    // highest (last_grant+1); the final match is the highest-priority one.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            automatic int idx = (int'(last_grant) + k) % N_REQ;
            if (req[idx]) begin
                grant_onehot      = '0;
                grant_onehot[idx] = 1'b1;
                grant_idx         = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte transmitter among N_REQ
// requesters, with a watchdog against a transmitter that never completes.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : master modport of uart_tx_scheduler_if (requests, acks,
//              transmitter handshake and status outputs)
// All outputs are registered.
module uart_tx_scheduler #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = uart_pkg::TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_scheduler_if.master bus
);
    import uart_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);

    sched_state_t     state;
    logic [IDX_W-1:0] last_grant;
    logic [WD_W-1:0]  wdog;
    logic [N_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0] arb_idx;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req          (bus.req_valid),
        .last_grant   (last_grant),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_grant      <= IDX_W'(N_REQ - 1);
            wdog            <= '0;
            bus.tx_start    <= 1'b0;
            bus.req_ack     <= '0;
            bus.tx_data     <= '0;
            bus.grant_id    <= '0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            // Start and ack are single-cycle pulses emitted in ISSUE only.
            bus.tx_start <= 1'b0;
            bus.req_ack  <= '0;
            case (state)
                IDLE: begin
                    if (bus.tx_ready && (|bus.req_valid)) begin
                        bus.tx_data  <= bus.req_data[arb_idx*DATA_W +: DATA_W];
                        bus.grant_id <= arb_idx;
                        bus.tx_start <= 1'b1;
                        bus.req_ack  <= arb_onehot;
                        bus.busy     <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    last_grant <= bus.grant_id;
                    wdog       <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    // Completion takes precedence over a simultaneous expiry.
                    if (bus.tx_done) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                        bus.timeout_err <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end else if (wdog != {WD_W{1'b1}}) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_scheduler;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int TO_CYC = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus_if ();

    uart_tx_scheduler #(
        .N_REQ       (N_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance until tx_start is seen, bounded by a cycle budget.
    task automatic wait_start(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_if.tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic pulse_done();
        bus_if.tx_done = 1'b1;
        tick(1);
        bus_if.tx_done = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start"}, {31'd0, bus_if.tx_start}, 32'd0);
        chk({tag, "_ack"},   {28'd0, bus_if.req_ack}, 32'd0);
        chk({tag, "_data"},  {24'd0, bus_if.tx_data}, 32'd0);
        chk({tag, "_gid"},   {30'd0, bus_if.grant_id}, 32'd0);
        chk({tag, "_busy"},  {31'd0, bus_if.busy}, 32'd0);
        chk({tag, "_terr"},  {31'd0, bus_if.timeout_err}, 32'd0);
    endtask

    initial begin
        int starts;
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        bus_if.tx_ready  = 1'b0;
        bus_if.tx_done   = 1'b0;
        tick(2);
        check_reset_vals("rst0");
        rst = 1'b0;
        tick(1);

        // Single request from requester 2.
        bus_if.req_data  = 32'h00A5_0000;
        bus_if.req_valid = 4'b0100;
        bus_if.tx_ready  = 1'b1;
        tick(1);
        chk("single_start", {31'd0, bus_if.tx_start}, 32'd1);
        chk("single_ack",   {28'd0, bus_if.req_ack}, 32'h4);
        chk("single_gid",   {30'd0, bus_if.grant_id}, 32'd2);
        chk("single_data",  {24'd0, bus_if.tx_data}, 32'hA5);
        bus_if.req_valid = '0;
        bus_if.req_data  = '0;
        tick(1);
        chk("single_start_w", {31'd0, bus_if.tx_start}, 32'd0);
        chk("single_ack_w",   {28'd0, bus_if.req_ack}, 32'd0);
        chk("single_busy",    {31'd0, bus_if.busy}, 32'd1);
        tick(5);
        chk("single_hold",    {24'd0, bus_if.tx_data}, 32'hA5);
        pulse_done();
        chk("single_idle",    {31'd0, bus_if.busy}, 32'd0);
        chk("single_hold2",   {24'd0, bus_if.tx_data}, 32'hA5);

        // Fairness with all requesters pending, starting from reset.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus_if.req_data  = 32'h1312_1110;
        bus_if.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_start($sformatf("rr_start%0d", g));
            chk($sformatf("rr_gid%0d", g), {30'd0, bus_if.grant_id}, {30'd0, order[g]});
            chk($sformatf("rr_ack%0d", g), {28'd0, bus_if.req_ack}, 32'd1 << order[g]);
            chk($sformatf("rr_data%0d", g), {24'd0, bus_if.tx_data}, 32'h10 + order[g]);
            if (g == 4) bus_if.req_valid = '0;
            tick(1);
            chk($sformatf("rr_ackw%0d", g), {28'd0, bus_if.req_ack}, 32'd0);
            tick(8);
            pulse_done();
        end

        // tx_ready low blocks arbitration.
        bus_if.tx_ready  = 1'b0;
        bus_if.req_valid = 4'b0010;
        starts = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bus_if.tx_start) starts++;
        end
        chk("rdy_nostart", starts, 32'd0);
        chk("rdy_idle", {31'd0, bus_if.busy}, 32'd0);
        bus_if.tx_ready = 1'b1;
        tick(1);
        chk("rdy_start", {31'd0, bus_if.tx_start}, 32'd1);
        chk("rdy_gid", {30'd0, bus_if.grant_id}, 32'd1);
        bus_if.req_valid = '0;
        tick(3);
        pulse_done();

        // Watchdog expiry: requester 3 wins (last served 1), 0 stays pending.
        bus_if.req_valid = 4'b1001;
        tick(1);
        chk("to_start", {31'd0, bus_if.tx_start}, 32'd1);
        chk("to_gid", {30'd0, bus_if.grant_id}, 32'd3);
        bus_if.req_valid = 4'b0001;
        tick(40);
        chk("to_busy_pre", {31'd0, bus_if.busy}, 32'd1);
        chk("to_err_pre", {31'd0, bus_if.timeout_err}, 32'd0);
        tick(1);
        chk("to_busy_post", {31'd0, bus_if.busy}, 32'd0);
        chk("to_err_post", {31'd0, bus_if.timeout_err}, 32'd1);
        tick(1);
        chk("to_next_start", {31'd0, bus_if.tx_start}, 32'd1);
        chk("to_next_gid", {30'd0, bus_if.grant_id}, 32'd0);
        chk("to_err_sticky", {31'd0, bus_if.timeout_err}, 32'd1);
        bus_if.req_valid = '0;
        tick(3);

        // Reset in the middle of WAIT takes effect immediately.
        rst = 1'b1;
        #1;
        check_reset_vals("rstw");
        tick(2);
        chk("rstw_nostart", {31'd0, bus_if.tx_start}, 32'd0);
        rst = 1'b0;
        bus_if.req_valid = 4'b1001;
        tick(1);
        chk("rstw_start", {31'd0, bus_if.tx_start}, 32'd1);
        chk("rstw_gid", {30'd0, bus_if.grant_id}, 32'd0);
        bus_if.req_valid = 4'b1000;

        // tx_done in the expiry cycle beats the watchdog.
        tick(40);
        chk("ex_busy_pre", {31'd0, bus_if.busy}, 32'd1);
        bus_if.tx_done = 1'b1;
        tick(1);
        bus_if.tx_done = 1'b0;
        chk("ex_idle", {31'd0, bus_if.busy}, 32'd0);
        chk("ex_noerr", {31'd0, bus_if.timeout_err}, 32'd0);
        tick(1);
        chk("ex_next_start", {31'd0, bus_if.tx_start}, 32'd1);
        chk("ex_next_gid", {30'd0, bus_if.grant_id}, 32'd3);
        bus_if.req_valid = '0;
        tick(3);
        pulse_done();
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares a single UART byte transmitter among `N_REQ` requesters, such as a loopback path fed by the receiver's `data_out`/`data_valid`, a status reporter, and a debug console. It arbitrates pending requests and latches the winner's byte. It then issues one start pulse to the transmitter and holds the data stable until the transmitter reports completion. A watchdog recovers from a transmitter that never completes.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, range 2..8.
- `DATA_W`, 8: byte width.
- `TIMEOUT_CYC`, 30000: maximum cycles in WAIT. This covers one 10-bit frame at 2500 clk/bit plus margin.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  N_REQ: per-requester byte pending.
- `req_data`  in  N_REQ*DATA_W: requester i's byte in bits [i*DATA_W +: DATA_W].
- `req_ack`  out  N_REQ: one-cycle pulse when requester i's byte is captured.
- `tx_ready`  in  1: transmitter idle and able to accept a start.
- `tx_done`  in  1: one-cycle pulse when the transmitter finishes the stop bit.
- `tx_start`  out  1: one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W: byte to transmit; stable from `tx_start` until `tx_done`.
- `grant_id`  out  clog2(N_REQ): index of the current or last granted requester.
- `busy`  out  1: high in ISSUE and WAIT.
- `timeout_err`  out  1: sticky; set on watchdog expiry.

## Operation
States: IDLE, ISSUE, WAIT.

IDLE:
- Arbitration runs when `tx_ready`=1 and any `req_valid` is set.
- Search starts at `last_grant+1`, wrapping modulo N_REQ. The first requester with `req_valid` set wins.
- On a win: latch its data into `tx_data`, load `grant_id`, go to ISSUE.
- If `tx_ready`=0, stay in IDLE; no grant is made.

ISSUE, lasting exactly 1 cycle:
- Assert `tx_start`=1 and `req_ack[grant_id]`=1.
- Set `last_grant` to `grant_id`.
- Clear the watchdog.
- Go to WAIT.

WAIT:
- The watchdog counts one per cycle.
- On `tx_done`: go to IDLE.
- Otherwise, when the count reaches TIMEOUT_CYC-1: set `timeout_err`, go to IDLE.
- `tx_done` and expiry in the same cycle: `tx_done` wins; `timeout_err` is not set.

Requester rules:
- A requester holds `req_valid` and its data until `req_ack`.
- Dropping `req_valid` before a grant withdraws the request without side effects.
- Changing `req_data` after the IDLE grant cycle has no effect on `tx_data`.

Fairness:
- After requester i is served, every other pending requester is served before i again.
- With all N_REQ requesters continuously pending, the order is 0,1,…,N_REQ-1,0,…

Counter width: clog2(TIMEOUT_CYC); the counter saturates and never wraps.

## Timing
Reset (asynchronous):
- State IDLE.
- `last_grant`=N_REQ-1, so requester 0 has first priority.
- Outputs: `tx_start`=0, `req_ack`=0, `tx_data`=0, `grant_id`=0, `busy`=0, `timeout_err`=0, watchdog=0.
- Reset asserted mid-WAIT aborts immediately. No ack or start is reissued after reset.

Latency:
- A request seen in IDLE with `tx_ready`=1 in cycle 0 gives `tx_start` and `req_ack` in cycle 1, and WAIT from cycle 2.
- After `tx_done` in cycle k, the scheduler is in IDLE in cycle k+1 and the earliest next `tx_start` is cycle k+2.

All outputs are registered. `req_ack` is one-hot or zero.

A `tx_done` received outside WAIT is ignored.

## Structure
Shared package `uart_pkg`:
- State encoding for IDLE, ISSUE and WAIT.
- Constants `CLK_PER_BIT`=2500, `FRAME_BITS`=10, and `TIMEOUT_CYC` derived from them.

Sub-module `rr_arbiter`:
- Inputs: `req` (N_REQ) and `last_grant`.
- Outputs: `grant_onehot` and `grant_idx`.
- Purely combinational.
- Also reused by the planned receive-side dispatcher.

## Test plan
- Single request: `req_valid[2]`=1 with data 8'hA5, `tx_ready`=1. Required: `tx_start` and `req_ack[2]` one cycle later, `tx_data`=8'hA5 stable until `tx_done`, `grant_id`=2.
- All four requesters pending continuously, `tx_done` 25000 cycles after each start. Required: grant order 0,1,2,3,0; each `req_ack` exactly one cycle wide.
- `tx_ready`=0 with requests pending for 100 cycles. Required: no `tx_start`. Raise `tx_ready`: start follows one cycle later.
- Withhold `tx_done`. Required: `timeout_err`=1 after TIMEOUT_CYC cycles in WAIT and return to IDLE; the next pending requester is served and `timeout_err` stays 1.
- `tx_done` in the exact expiry cycle. Required: `timeout_err` stays 0.
- Assert `rst` mid-WAIT. Required: all outputs at reset values immediately. After release, requester 0 wins over 3 when both are pending.
